mux_op_sequencer: RTL and testbench

//  Upstream driver for the N-bit 8-to-1 operation mux (mux8to1). Accepts one

---
 rtl/mux_op_sequencer_pkg.sv | 12 +
 rtl/mux_op_sequencer_if.sv | 28 ++
 rtl/mux_op_sequencer.sv | 96 +++++++++
 tb/tb_mux_op_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_op_sequencer_pkg.sv
// Shared constants for the mux operation sequencer: select width, FSM state
// encodings and the first select code of a sweep.
package mux_op_sequencer_pkg;

  localparam int unsigned SEL_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [SEL_W-1:0] SEL_MIN = 3'b000;

endpackage

// File: rtl/mux_op_sequencer_if.sv
// Operand-in / result-out stream bundle of the mux operation sequencer.
// The sequencer is the slave; the upstream/downstream environment is the master.
interface mux_op_sequencer_if
  import mux_op_sequencer_pkg::*;
#(
  parameter int N = 9
);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_a;
  logic [N-1:0]     in_b;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_y;
  logic [SEL_W-1:0] out_sel;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_y, out_sel
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_y, out_sel
  );

endinterface

// File: rtl/mux_op_sequencer.sv
// Drives an external 8-to-1 operation mux: latches one operand pair, sweeps the
// select code 0..LAST_SEL and streams each registered mux result downstream.
module mux_op_sequencer #(
  parameter int N        = 9,
  parameter int LAST_SEL = 7
) (
  input  logic                clk,
  input  logic                rst,
  mux_op_sequencer_if.slave   bus,
  output logic [N-1:0]        o_mux_a,
  output logic [N-1:0]        o_mux_b,
  output logic                o_mux_i1,
  output logic                o_mux_i2,
  output logic                o_mux_i3,
  input  logic [N-1:0]        i_mux_y,
  output logic                o_busy,
  output logic                o_done
);

  import mux_op_sequencer_pkg::*;

  localparam logic [SEL_W-1:0] LAST_CODE = SEL_W'(LAST_SEL);

  logic [0:0]       r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N-1:0]     r_mux_a;
  logic [N-1:0]     r_mux_b;
  logic             r_out_valid;
  logic [N-1:0]     r_out_y;
  logic [SEL_W-1:0] r_out_sel;
  logic             r_done;
  logic             w_capture;

  // A capture needs the output slot free now or freed by the consumer this edge.
  assign w_capture = (r_state == ST_RUN) && (!r_out_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sel       <= SEL_MIN;
      r_mux_a     <= '0;
      r_mux_b     <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
      r_out_sel   <= SEL_MIN;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_capture) begin
        r_out_y     <= i_mux_y;
        r_out_sel   <= r_sel;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_mux_a <= bus.in_a;
            r_mux_b <= bus.in_b;
            r_sel   <= SEL_MIN;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_capture) begin
            if (r_sel == LAST_CODE) begin
              r_sel   <= SEL_MIN;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_sel <= r_sel + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_y     = r_out_y;
  assign bus.out_sel   = r_out_sel;

  assign o_mux_a  = r_mux_a;
  assign o_mux_b  = r_mux_b;
  assign o_mux_i1 = r_sel[2];
  assign o_mux_i2 = r_sel[1];
  assign o_mux_i3 = r_sel[0];
  assign o_busy   = (r_state == ST_RUN);
  assign o_done   = r_done;

endmodule

// File: tb/tb_mux_op_sequencer.sv
// Bench for mux_op_sequencer: directed scenarios plus random traffic, scored
// against a queue of expected (sel, y) results derived from accepted operands.
module tb_mux_op_sequencer;

  typedef struct {
    logic [8:0] y;
    logic [2:0] sel;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  res_t        q[$];

  // Reference operation mux (stands in for mux8to1 in the parent).
  function automatic logic [8:0] ref_op(logic [8:0] a, logic [8:0] b, logic [2:0] s);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << 1;
      default: return b >> 1;
    endcase
  endfunction

  // ---- DUT 1: default sweep 0..7 ----
  mux_op_sequencer_if #(.N(9)) b1 ();
  logic [8:0] m1a, m1b, m1y;
  logic       m1i1, m1i2, m1i3, busy1, done1;
  assign m1y = ref_op(m1a, m1b, {m1i1, m1i2, m1i3});

  mux_op_sequencer #(.N(9), .LAST_SEL(7)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave),
    .o_mux_a(m1a), .o_mux_b(m1b),
    .o_mux_i1(m1i1), .o_mux_i2(m1i2), .o_mux_i3(m1i3),
    .i_mux_y(m1y), .o_busy(busy1), .o_done(done1)
  );

  // ---- DUT 2: short sweep 0..3 ----
  mux_op_sequencer_if #(.N(9)) b2 ();
  logic [8:0] m2a, m2b, m2y;
  logic       m2i1, m2i2, m2i3, busy2, done2;
  assign m2y = ref_op(m2a, m2b, {m2i1, m2i2, m2i3});

  mux_op_sequencer #(.N(9), .LAST_SEL(3)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave),
    .o_mux_a(m2a), .o_mux_b(m2b),
    .o_mux_i1(m2i1), .o_mux_i2(m2i2), .o_mux_i3(m2i3),
    .i_mux_y(m2y), .o_busy(busy2), .o_done(done2)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the handshake/acceptance seen before the edge, then
  // sample outputs 1 time unit after it.
  task automatic step();
    logic       hs, acc, rs;
    logic [8:0] y, a, b;
    logic [2:0] s;
    res_t       e;
    hs  = b1.out_valid && b1.out_ready;
    y   = b1.out_y;
    s   = b1.out_sel;
    acc = b1.in_valid && b1.in_ready;
    a   = b1.in_a;
    b   = b1.in_b;
    rs  = rst;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
    end else begin
      if (hs) begin
        check("result_expected", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          check("out_sel", 32'(s), 32'(e.sel));
          check("out_y", 32'(y), 32'(e.y));
        end
      end
      if (acc)
        for (int unsigned k = 0; k < 8; k++)
          q.push_back('{y: ref_op(a, b, 3'(k)), sel: 3'(k)});
    end
    if (done1) begin
      check("done_sel", 32'(b1.out_sel), 32'd7);
      check("done_valid", 32'(b1.out_valid), 32'd1);
      check("done_in_ready", 32'(b1.in_ready), 32'd1);
    end
    check("ready_vs_busy", 32'(b1.in_ready), 32'(!busy1));
  endtask

  task automatic run_to_done(output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = done1;
    end
  endtask

  task automatic offer(logic [8:0] a, logic [8:0] b);
    b1.in_valid = 1'b1;
    b1.in_a     = a;
    b1.in_b     = b;
    step();
    b1.in_valid = 1'b0;
  endtask

  initial begin
    logic        seen;
    int unsigned nvalid, cnt;
    logic [8:0]  ra, rb;

    b1.in_valid = 1'b0; b1.in_a = '0; b1.in_b = '0; b1.out_ready = 1'b1;
    b2.in_valid = 1'b0; b2.in_a = '0; b2.in_b = '0; b2.out_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check("rst_in_ready", 32'(b1.in_ready), 32'd1);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_out_valid", 32'(b1.out_valid), 32'd0);
    check("rst_out_y", 32'(b1.out_y), 32'd0);
    check("rst_out_sel", 32'(b1.out_sel), 32'd0);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_sel", 32'({m1i1, m1i2, m1i3}), 32'd0);
    check("rst_mux_a", 32'(m1a), 32'd0);

    // Full sweep with out_ready held high: 8 consecutive results
    offer(9'h00F, 9'h006);
    check("accept_busy", 32'(busy1), 32'd1);
    check("accept_mux_a", 32'(m1a), 32'h00F);
    check("accept_mux_b", 32'(m1b), 32'h006);
    nvalid = 0;
    seen   = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (b1.out_valid) nvalid++;
      seen = done1;
    end
    check("sweep1_done", 32'(seen), 32'd1);
    check("sweep1_consecutive", nvalid, 32'd8);

    // Back-pressure at out_sel=2, with ignored operands offered while busy
    offer(9'h0A5, 9'h13C);
    for (int i = 0; i < 20 && !(b1.out_valid && b1.out_sel == 3'd2); i++) step();
    check("stall_reach", 32'(b1.out_sel), 32'd2);
    b1.out_ready = 1'b0;
    b1.in_valid  = 1'b1;
    b1.in_a      = 9'h1FF;
    b1.in_b      = 9'h000;
    for (int i = 0; i < 3; i++) begin
      check("busy_in_ready", 32'(b1.in_ready), 32'd0);
      step();
      check("stall_out_sel", 32'(b1.out_sel), 32'd2);
      check("stall_out_y", 32'(b1.out_y), 32'(ref_op(9'h0A5, 9'h13C, 3'd2)));
      check("stall_sel_out", 32'({m1i1, m1i2, m1i3}), 32'd3);
      check("stall_mux_a", 32'(m1a), 32'h0A5);
      check("stall_mux_b", 32'(m1b), 32'h13C);
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    run_to_done(seen);
    check("stall_done", 32'(seen), 32'd1);
    step(); step();

    // Reset mid-sweep at sel=4
    offer(9'h033, 9'h0C1);
    for (int i = 0; i < 20 && {m1i1, m1i2, m1i3} != 3'd4; i++) step();
    check("abort_reach", 32'({m1i1, m1i2, m1i3}), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_valid", 32'(b1.out_valid), 32'd0);
    check("abort_busy", 32'(busy1), 32'd0);
    check("abort_in_ready", 32'(b1.in_ready), 32'd1);
    check("abort_sel", 32'({m1i1, m1i2, m1i3}), 32'd0);
    check("abort_mux_a", 32'(m1a), 32'd0);
    check("abort_out_y", 32'(b1.out_y), 32'd0);
    offer(9'h155, 9'h0AA);
    run_to_done(seen);
    check("post_abort_done", 32'(seen), 32'd1);
    step();

    // Short-sweep build: exactly 4 results, done at out_sel=3
    b2.in_valid = 1'b1;
    b2.in_a     = 9'h0F0;
    b2.in_b     = 9'h00F;
    step();
    b2.in_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b2.out_valid) begin
        check("short_sel", 32'(b2.out_sel), cnt);
        check("short_y", 32'(b2.out_y), 32'(ref_op(9'h0F0, 9'h00F, 3'(cnt))));
        cnt++;
      end
      if (done2) check("short_done_sel", 32'(b2.out_sel), 32'd3);
    end
    check("short_count", cnt, 32'd4);

    // Back-to-back: next pair offered while done pulses, slot still occupied
    offer(9'h001, 9'h002);
    for (int i = 0; i < 20 && !done1; i++) step();
    check("b2b_done", 32'(done1), 32'd1);
    b1.in_valid  = 1'b1;
    b1.in_a      = 9'h0FE;
    b1.in_b      = 9'h011;
    b1.out_ready = 1'b0;
    step();
    b1.in_valid  = 1'b0;
    check("b2b_accepted", 32'(busy1), 32'd1);
    check("b2b_hold_sel", 32'(b1.out_sel), 32'd7);
    check("b2b_hold_valid", 32'(b1.out_valid), 32'd1);
    b1.out_ready = 1'b1;
    step();
    check("b2b_first_sel", 32'(b1.out_sel), 32'd0);
    check("b2b_first_y", 32'(b1.out_y), 32'(ref_op(9'h0FE, 9'h011, 3'd0)));
    run_to_done(seen);
    check("b2b_second_done", 32'(seen), 32'd1);

    // Random traffic with random back-pressure
    for (int i = 0; i < 600; i++) begin
      ra = 9'($urandom);
      rb = 9'($urandom);
      b1.in_valid  = ($urandom_range(0, 3) == 0);
      b1.in_a      = ra;
      b1.in_b      = rb;
      b1.out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("drain_empty", q.size(), 32'd0);
    check("drain_idle", 32'(b1.in_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
